// File: rtl/riscv_pkg.sv
// Constants shared between the fetch and decode stages of the RISC-V core.
package riscv_pkg;

  // Canonical no-op (addi x0, x0, 0), shown to decode whenever no instruction is present.
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          INSTR_BYTES = 4;

  // Major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode-facing side.
interface fetch_unit_if #(
  parameter int ADDRESS_BITS = 16
);
  logic                    imem_req_valid;
  logic                    imem_req_ready;
  logic [ADDRESS_BITS-1:0] imem_addr;
  logic                    imem_resp_valid;
  logic [31:0]             imem_resp_data;
  logic                    next_PC_select;
  logic [ADDRESS_BITS-1:0] target_PC;
  logic                    stall;
  logic                    instr_valid;
  logic [ADDRESS_BITS-1:0] PC;
  logic [31:0]             instr;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_addr, instr_valid, PC, instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, next_PC_select, target_PC, stall
  );

  // Environment side: instruction memory and decode.
  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, PC, instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, next_PC_select, target_PC, stall
  );
endinterface

// File: rtl/fetch_queue.sv
// QDEPTH-entry FIFO of {pc, instr} pairs between imem responses and decode.
module fetch_queue #(
  parameter int ADDRESS_BITS = 16,
  parameter int QDEPTH       = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push,
  input  logic [ADDRESS_BITS-1:0]        push_pc,
  input  logic [31:0]                    push_instr,
  input  logic                           pop,
  output logic [ADDRESS_BITS-1:0]        head_pc,
  output logic [31:0]                    head_instr,
  output logic [$clog2(QDEPTH+1)-1:0]    count,
  output logic                           full,
  output logic                           empty
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [ADDRESS_BITS-1:0] pc_mem    [QDEPTH];
  logic [31:0]             instr_mem [QDEPTH];
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    do_push, do_pop;

  // Pointer/occupancy update; flush overrides push and pop.
  // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latch).
  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state registers.
  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write.
  // NOTE: storage is not reset; only entries below count are ever presented, so stale data is invisible.
  always_ff @(posedge clock) begin
    if (do_push) begin
      pc_mem[wr_ptr_q]    <= push_pc;
      instr_mem[wr_ptr_q] <= push_instr;
    end
  end

  assign head_pc    = pc_mem[rd_ptr_q];
  assign head_instr = instr_mem[rd_ptr_q];
  assign count      = count_q;
  assign full       = (count_q == CW'(QDEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues imem requests, queues returned
// words with their PCs for decode, and discards wrong-path words after a redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                      ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0,
  parameter int                      QDEPTH       = 2
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int            CW   = $clog2(QDEPTH + 1);
  localparam logic [CW:0]   QCAP = (CW+1)'(QDEPTH);

  logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target_aligned;
  logic [CW-1:0]           outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, q_count;
  logic [CW:0]             in_use;
  logic                    redirect, req_fire, resp_fire, resp_keep, push, pop, q_full, q_empty;
  logic [ADDRESS_BITS-1:0] head_pc;
  logic [31:0]             head_instr;
  logic                    unused_target_low;

  // Word alignment drops the two low target bits on purpose.
  assign unused_target_low = ^bus.target_PC[1:0];

  // Request issue and handshake qualifiers; in-flight plus queued words never exceed QDEPTH,
  // which guarantees every response has a queue slot.
  always_comb begin
    redirect           = bus.next_PC_select;
    in_use             = {1'b0, outstanding_q} + {1'b0, q_count};
    bus.imem_req_valid = reset && !redirect && (in_use < QCAP);
    req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    resp_fire          = bus.imem_resp_valid;
    resp_keep          = resp_fire && (drop_cnt_q == '0);
    push               = resp_keep && !redirect;
    pop                = !q_empty && !bus.stall && !redirect;
    target_aligned     = {bus.target_PC[ADDRESS_BITS-1:2], 2'b00};
  end

  // Fetch-control next state; a redirect overrides everything else.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_fire);
    if (redirect) begin
      fetch_pc_d = target_aligned;
      resp_pc_d  = target_aligned;
      // Every word still in flight after this edge belongs to the abandoned path.
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire)              fetch_pc_d = fetch_pc_q + ADDRESS_BITS'(INSTR_BYTES);
      if (resp_fire && !resp_keep) drop_cnt_d = drop_cnt_q - CW'(1);
      if (push)                  resp_pc_d  = resp_pc_q + ADDRESS_BITS'(INSTR_BYTES);
    end
  end

  // Fetch-control registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_queue #(
    .ADDRESS_BITS (ADDRESS_BITS),
    .QDEPTH       (QDEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_pc    (resp_pc_q),
    .push_instr (bus.imem_resp_data),
    .pop        (pop),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = !q_empty;
  assign bus.PC          = q_empty ? '0 : head_pc;
  assign bus.instr       = q_empty ? NOP_INSTR : head_instr;

  // imem returning more words than were requested would overflow the queue.
  assert property (@(posedge clock) disable iff (!reset) !(push && q_full));

endmodule
